uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [2:0] {
    IDLE_ST   = 3'd0,
    START_ST  = 3'd1,
    DATA_ST   = 3'd2,
    STOP_ST   = 3'd3,
    PARITY_ST = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && (!full || rd_en);
    do_rd    = rd_en && !empty;
    mem_d    = mem_q;
    if (do_wr) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive engine with runtime divisor, sticky error flags and FWFT byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          nRST,
  input  logic                          rx_input_data,
  input  logic                          rx_en,
  input  logic                          div_load,
  input  logic [15:0]                   div_value,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          err_clr,
  output logic [2:0]                    rx_state
);
  import uart_pkg::*;

  rx_state_t   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic        rx_s, push, set_ferr, fifo_full, fifo_empty, par_bad;
  logic [15:0] half_m1, full_m1;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d, set_perr;
  assign par_bad    = par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign rx_s     = sync_q[1];
  assign half_m1  = {1'b0, div_q[15:1]} - 16'd1;
  assign full_m1  = div_q - 16'd1;
  assign rx_state = state_q;
  assign rd_valid = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun  = overrun_q;

  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[0], rx_input_data};
    div_d    = div_q;
    cnt_d    = cnt_q + 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    set_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    set_perr  = 1'b0;
`endif
    case (state_q)
      IDLE_ST: begin
        cnt_d = '0;
        bit_d = '0;
        if (div_load && div_value >= DIV_MIN) div_d = div_value;
        if (rx_en && !rx_s) state_d = START_ST;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      START_ST: if (cnt_q == half_m1) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s ? IDLE_ST : DATA_ST;
      end
      DATA_ST: if (cnt_q == full_m1) begin
        cnt_d   = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY_ST;
`else
          state_d = STOP_ST;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_ST: if (cnt_q == full_m1) begin
        cnt_d     = '0;
        par_bad_d = (rx_s != ^shift_q);
        set_perr  = par_bad_d;
        state_d   = STOP_ST;
      end
`endif
      STOP_ST: if (cnt_q == full_m1) begin
        cnt_d   = '0;
        state_d = IDLE_ST;
        if (!rx_s)        set_ferr = 1'b1;
        else if (!par_bad) push    = 1'b1;
      end
      default: state_d = IDLE_ST;
    endcase
    // A flag raised in the same cycle as err_clr stays set.
    frame_err_d = set_ferr | (frame_err_q & ~err_clr);
    overrun_d   = (push & fifo_full & ~rd_en) | (overrun_q & ~err_clr);
`ifdef UART_RX_PARITY_EN
    parity_err_d = set_perr | (parity_err_q & ~err_clr);
`endif
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q     <= IDLE_ST;
      sync_q      <= '1;
      div_q       <= 16'(CLKS_PER_BIT);
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nRST    (nRST),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame table at a loaded divisor plus corner sequences.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        nRST, rx_input_data, rx_en, div_load, rd_en, err_clr;
  logic [15:0] div_value;
  logic [7:0]  rd_data;
  logic        rd_valid, frame_err, overrun, parity_err;
  logic [3:0]  fifo_count;
  logic [2:0]  rx_state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         pulse;     // 0 none, 1 rd_en at push edge, 2 err_clr at push edge, 3 div_load mid-frame
    logic [7:0] exp_data;
    int         exp_count;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  uart_rx_ctrl #(.CLKS_PER_BIT(434), .FIFO_DEPTH(8)) dut (
    .clk           (clk),
    .nRST          (nRST),
    .rx_input_data (rx_input_data),
    .rx_en         (rx_en),
    .div_load      (div_load),
    .div_value     (div_value),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .fifo_count    (fifo_count),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .parity_err    (parity_err),
    .err_clr       (err_clr),
    .rx_state      (rx_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bitlen, input int pulse);
    rx_input_data = 1'b0;
    repeat (bitlen) tick();
    for (int k = 0; k < 8; k++) begin
      rx_input_data = b[k];
      for (int i = 0; i < bitlen; i++) begin
        if (pulse == 3 && k == 3 && i == 0) begin div_load = 1'b1; div_value = 16'd8; end
        if (pulse == 3 && k == 3 && i == 1) div_load = 1'b0;
        tick();
      end
    end
`ifdef UART_RX_PARITY_EN
    rx_input_data = ^b;
    repeat (bitlen) tick();
`endif
    rx_input_data = stop;
    for (int i = 0; i < bitlen; i++) begin
      // Stop sample lands on the edge 3 + bitlen/2 cycles into the stop bit.
      if (i == 2 + bitlen / 2) begin
        if (pulse == 1) rd_en = 1'b1;
        if (pulse == 2) err_clr = 1'b1;
      end
      if (i == 3 + bitlen / 2) begin rd_en = 1'b0; err_clr = 1'b0; end
      tick();
    end
    rx_input_data = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h5A, 1'b1, 0, 8'h5A, 1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 8'h00, 1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0, 8'hFF, 1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 0, 8'h80, 1, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 3, 8'h5A, 1, 1'b0};
    vecs[5] = '{8'hC3, 1'b0, 0, 8'h00, 0, 1'b1};
    vecs[6] = '{8'h3C, 1'b0, 2, 8'h00, 0, 1'b1};

    nRST = 1'b0; rx_input_data = 1'b1; rx_en = 1'b1; div_load = 1'b0;
    div_value = '0; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_state", rx_state, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    nRST = 1'b1;
    repeat (2) tick();

    send_frame(8'hA5, 1'b1, 434, 0);
    check("a5_data", rd_data, 8'hA5);
    check("a5_valid", rd_valid, 1);
    check("a5_count", fifo_count, 1);
    check("a5_flags", {frame_err, overrun, parity_err}, 0);
    pop();
    check("a5_pop_count", fifo_count, 0);
    check("a5_pop_valid", rd_valid, 0);
    pop();
    check("empty_pop_count", fifo_count, 0);

    rx_input_data = 1'b0;
    repeat (50) tick();
    check("glitch_in_start", rx_state, 1);
    repeat (50) tick();
    rx_input_data = 1'b1;
    repeat (300) tick();
    check("glitch_idle", rx_state, 0);
    check("glitch_count", fifo_count, 0);
    check("glitch_flags", {frame_err, overrun, parity_err}, 0);

    send_frame(8'h3C, 1'b0, 434, 0);
    check("ferr_set", frame_err, 1);
    check("ferr_count", fifo_count, 0);
    clr();
    check("ferr_clr", frame_err, 0);

    div_load = 1'b1; div_value = 16'd3; tick(); div_load = 1'b0;
    rx_input_data = 1'b0;
    repeat (20) tick();
    check("div3_ignored", rx_state, 1);
    rx_input_data = 1'b1;
    repeat (300) tick();
    check("div3_idle", rx_state, 0);

    div_load = 1'b1; div_value = 16'd16; tick(); div_load = 1'b0;
    repeat (4) tick();

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, 16, vecs[v].pulse);
      check($sformatf("vec%0d_count", v), fifo_count, vecs[v].exp_count);
      check($sformatf("vec%0d_ferr", v), frame_err, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), overrun, 0);
      if (vecs[v].exp_count > 0) begin
        check($sformatf("vec%0d_data", v), rd_data, vecs[v].exp_data);
        check($sformatf("vec%0d_valid", v), rd_valid, 1);
        pop();
      end
      clr();
      check($sformatf("vec%0d_after", v), {fifo_count, frame_err}, 0);
    end

    for (int n = 1; n <= 9; n++) send_frame(8'(n), 1'b1, 16, 0);
    check("ovr_count", fifo_count, 8);
    check("ovr_flag", overrun, 1);
    check("ovr_head", rd_data, 8'h01);
    for (int n = 1; n <= 8; n++) begin
      check($sformatf("ovr_pop%0d", n), rd_data, 8'(n));
      pop();
    end
    check("ovr_drained", fifo_count, 0);
    clr();
    check("ovr_clr", overrun, 0);

    for (int n = 0; n < 8; n++) send_frame(8'h11 + 8'(n), 1'b1, 16, 0);
    check("full_count", fifo_count, 8);
    send_frame(8'h19, 1'b1, 16, 1);
    check("fullrw_count", fifo_count, 8);
    check("fullrw_ovr", overrun, 0);
    check("fullrw_head", rd_data, 8'h12);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("fullrw_pop%0d", n), rd_data, 8'h12 + 8'(n));
      pop();
    end
    check("fullrw_drained", fifo_count, 0);

    send_frame(8'h77, 1'b1, 16, 0);
    check("pre_rst_count", fifo_count, 1);
    rx_input_data = 1'b0;
    repeat (16 + 4 * 16 + 8) tick();
    check("mid_data_state", rx_state, 2);
    nRST = 1'b0; rx_input_data = 1'b1;
    repeat (2) tick();
    check("midrst_state", rx_state, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_valid", rd_valid, 0);
    nRST = 1'b1;
    repeat (20) tick();
    check("post_rst_count", fifo_count, 0);
    send_frame(8'hFF, 1'b1, 434, 0);
    check("ff_data", rd_data, 8'hFF);
    check("ff_count", fifo_count, 1);
    check("ff_flags", {frame_err, overrun, parity_err}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
